// File: rtl/supersonic_ranger_mc_pkg.sv
// ============================================================================
// Module   : supersonic_ranger_mc_pkg
// Brief    : FSM state encodings, 50 MHz timing defaults and sizing helpers
//            for the multi-channel ultrasonic ranger.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package supersonic_ranger_mc_pkg;

    localparam int c_ST_W = 3;
    localparam logic [c_ST_W-1:0] c_ST_IDLE      = 3'd0;
    localparam logic [c_ST_W-1:0] c_ST_TRIG      = 3'd1;
    localparam logic [c_ST_W-1:0] c_ST_WAIT_RISE = 3'd2;
    localparam logic [c_ST_W-1:0] c_ST_MEASURE   = 3'd3;
    localparam logic [c_ST_W-1:0] c_ST_RESULT    = 3'd4;
    localparam logic [c_ST_W-1:0] c_ST_GAP       = 3'd5;

    localparam int c_TRIG_CYC_50M    = 500;
    localparam int c_CM_DIV_50M      = 2900;
    localparam int c_TIMEOUT_CYC_50M = 1500000;
    localparam int c_GAP_CYC_50M     = 3000000;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // A single-channel build still needs a 1-bit channel index.
    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

`default_nettype wire

// File: rtl/supersonic_ranger_mc_echo_sync.sv
// ============================================================================
// Module   : supersonic_ranger_mc_echo_sync
// Brief    : 2-FF synchroniser for one echo pin with rise/fall pulses.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module supersonic_ranger_mc_echo_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic echo_i,
    output logic rise_o,
    output logic fall_o
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= echo_i;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign rise_o = r_sync & ~r_prev;
    assign fall_o = ~r_sync & r_prev;

endmodule

`default_nettype wire

// File: rtl/supersonic_ranger_mc.sv
// ============================================================================
// Module   : supersonic_ranger_mc
// Brief    : Round-robin HC-SR04 class ranging engine: trigger, echo width to
//            cm, timeout and proximity flag per channel.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module supersonic_ranger_mc
    import supersonic_ranger_mc_pkg::*;
#(
    parameter int N_CH        = 2,
    parameter int DIST_W      = 16,
    parameter int TRIG_CYC    = c_TRIG_CYC_50M,
    parameter int CM_DIV      = c_CM_DIV_50M,
    parameter int TIMEOUT_CYC = c_TIMEOUT_CYC_50M,
    parameter int GAP_CYC     = c_GAP_CYC_50M
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_i,
    input  logic                     stop_i,
    input  logic                     pause_i,
    input  logic                     mode_i,
    input  logic [DIST_W-1:0]        thresh_i,
    input  logic [N_CH-1:0]          echo_i,
    output logic [N_CH-1:0]          trig_o,
    output logic [N_CH*DIST_W-1:0]   dist_o,
    output logic [N_CH-1:0]          near_o,
    output logic [N_CH-1:0]          timeout_o,
    output logic                     valid_o,
    output logic [ch_width(N_CH)-1:0] ch_o,
    output logic                     busy_o,
    output logic                     done_o
);

    localparam int c_CH_W  = ch_width(N_CH);
    localparam int c_TMR_W = $clog2(max3(TRIG_CYC, TIMEOUT_CYC, GAP_CYC) + 1);
    localparam int c_PRE_W = $clog2(CM_DIV + 1);

    localparam logic [c_TMR_W-1:0] c_TRIG_LAST = c_TMR_W'(TRIG_CYC - 1);
    localparam logic [c_TMR_W-1:0] c_TMO_LAST  = c_TMR_W'(TIMEOUT_CYC - 1);
    localparam logic [c_TMR_W-1:0] c_GAP_LAST  = c_TMR_W'(GAP_CYC - 1);
    localparam logic [c_PRE_W-1:0] c_PRE_LAST  = c_PRE_W'(CM_DIV - 1);
    localparam logic [c_CH_W-1:0]  c_CH_LAST   = c_CH_W'(N_CH - 1);

    generate
        if (N_CH < 1 || N_CH > 8 || TRIG_CYC < 1 || CM_DIV < 1 ||
            TIMEOUT_CYC < 1 || GAP_CYC < 1) begin : g_param_check
            $error("supersonic_ranger_mc: illegal parameter set");
        end
    endgenerate

    logic [c_ST_W-1:0]  r_state;
    logic [c_ST_W-1:0]  w_next;
    logic [c_TMR_W-1:0] r_timer;
    logic [c_PRE_W-1:0] r_presc;
    logic [c_PRE_W-1:0] w_presc_nxt;
    logic [DIST_W-1:0]  r_cnt;
    logic [DIST_W-1:0]  w_cnt_nxt;
    logic [c_CH_W-1:0]  r_ch;
    logic [c_CH_W-1:0]  r_ch_o;
    logic [DIST_W-1:0]  r_dist [N_CH];
    logic [N_CH-1:0]    r_near;
    logic [N_CH-1:0]    r_tmo;
    logic [N_CH-1:0]    w_rise_v;
    logic [N_CH-1:0]    w_fall_v;
    logic               w_rise;
    logic               w_fall;
    logic               w_tmo_hit;
    logic               w_gap_exit;
    logic               w_res_tmo;
    logic               w_capture;

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_sync
            supersonic_ranger_mc_echo_sync u_sync (
                .clk    (clk),
                .rst_n  (rst_n),
                .echo_i (echo_i[k]),
                .rise_o (w_rise_v[k]),
                .fall_o (w_fall_v[k])
            );
        end
    endgenerate

    assign w_rise      = w_rise_v[r_ch];
    assign w_fall      = w_fall_v[r_ch];
    assign w_tmo_hit   = (r_timer == c_TMO_LAST);
    assign w_gap_exit  = (r_state == c_ST_GAP) && (r_timer == c_GAP_LAST) && !pause_i;
    assign w_presc_nxt = (r_presc == c_PRE_LAST) ? '0 : r_presc + c_PRE_W'(1);
    assign w_cnt_nxt   = (r_presc == c_PRE_LAST && r_cnt != '1) ? r_cnt + DIST_W'(1) : r_cnt;
    // An echo fall on the timeout cycle still yields a normal measurement.
    assign w_res_tmo   = (r_state == c_ST_WAIT_RISE) || !w_fall;
    assign w_capture   = (w_next == c_ST_RESULT) && (r_state != c_ST_RESULT);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_ST_IDLE:      if (start_i && !pause_i) w_next = c_ST_TRIG;
            c_ST_TRIG:      if (r_timer == c_TRIG_LAST) w_next = c_ST_WAIT_RISE;
            c_ST_WAIT_RISE: begin
                if (w_tmo_hit)   w_next = c_ST_RESULT;
                else if (w_rise) w_next = c_ST_MEASURE;
            end
            c_ST_MEASURE:   if (w_fall || w_tmo_hit) w_next = c_ST_RESULT;
            c_ST_RESULT:    w_next = c_ST_GAP;
            c_ST_GAP: begin
                if (w_gap_exit) begin
                    if (r_ch != c_CH_LAST || mode_i) w_next = c_ST_TRIG;
                    else                             w_next = c_ST_IDLE;
                end
            end
            default:        w_next = c_ST_IDLE;
        endcase
        if (stop_i) w_next = c_ST_IDLE;
    end

    always_comb begin
        trig_o = '0;
        if (r_state == c_ST_TRIG) trig_o[r_ch] = 1'b1;
        valid_o = (r_state == c_ST_RESULT);
        busy_o  = (r_state != c_ST_IDLE);
        done_o  = w_gap_exit && (r_ch == c_CH_LAST) && !stop_i;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_timer <= '0;
            r_presc <= '0;
            r_cnt   <= '0;
            r_ch    <= '0;
            r_ch_o  <= '0;
            r_near  <= '0;
            r_tmo   <= '0;
            for (int k = 0; k < N_CH; k++) r_dist[k] <= '0;
        end else begin
            // The timeout window spans WAIT_RISE and MEASURE, so that hand-off keeps counting.
            if (r_state == c_ST_WAIT_RISE && w_next == c_ST_MEASURE) begin
                r_timer <= r_timer + c_TMR_W'(1);
            end else if (w_next != r_state) begin
                r_timer <= '0;
            end else if (r_state == c_ST_TRIG || r_state == c_ST_WAIT_RISE ||
                         r_state == c_ST_MEASURE ||
                         (r_state == c_ST_GAP && r_timer != c_GAP_LAST)) begin
                r_timer <= r_timer + c_TMR_W'(1);
            end

            if (r_state == c_ST_WAIT_RISE && w_next == c_ST_MEASURE) begin
                r_presc <= '0;
                r_cnt   <= '0;
            end else if (r_state == c_ST_MEASURE) begin
                r_presc <= w_presc_nxt;
                r_cnt   <= w_cnt_nxt;
            end

            if (w_capture) begin
                r_ch_o <= r_ch;
                if (w_res_tmo) begin
                    r_dist[r_ch] <= '1;
                    r_tmo[r_ch]  <= 1'b1;
                    r_near[r_ch] <= 1'b0;
                end else begin
                    r_dist[r_ch] <= w_cnt_nxt;
                    r_tmo[r_ch]  <= 1'b0;
                    r_near[r_ch] <= (w_cnt_nxt < thresh_i);
                end
            end

            if (w_next == c_ST_IDLE) begin
                r_ch <= '0;
            end else if (w_gap_exit && w_next == c_ST_TRIG) begin
                r_ch <= (r_ch == c_CH_LAST) ? '0 : r_ch + c_CH_W'(1);
            end
        end
    end

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_dist
            assign dist_o[k*DIST_W +: DIST_W] = r_dist[k];
        end
    endgenerate

    assign near_o    = r_near;
    assign timeout_o = r_tmo;
    assign ch_o      = r_ch_o;

endmodule

`default_nettype wire
